// File: rtl/turn_countdown_if.sv
// Bundle of game-FSM <-> turn countdown signals.
// Signalling: start and move_done are single-cycle request pulses. They are
// taken on the rising edge where they are high, with no acknowledge.
// load_secs only matters in a cycle where start is high. pause is a level.
// On the status side, remaining, running and dbg_state are registered levels.
// sec_tick and expired are registered one-cycle pulses.
interface turn_countdown_if #(
  parameter int SEC_W = 6
);
  logic             start;
  logic [SEC_W-1:0] load_secs;
  logic             pause;
  logic             move_done;
  logic [SEC_W-1:0] remaining;
  logic             running;
  logic             sec_tick;
  logic             expired;
  logic [1:0]       dbg_state;

  // Game FSM side: arms, pauses and cancels; watches the status.
  modport master (
    output start, load_secs, pause, move_done,
    input  remaining, running, sec_tick, expired, dbg_state
  );

  // Countdown side.
  modport slave (
    input  start, load_secs, pause, move_done,
    output remaining, running, sec_tick, expired, dbg_state
  );
endinterface

// File: rtl/turn_countdown.sv
// Per-turn seconds countdown with a built-in 1 s prescaler.
// Each cycle the highest-priority event wins, in this order:
// start, then move_done, then pause, then the prescaler terminal count.
// A PAUSED cycle with pause low counts like RUN, so a held partial second
// resumes from the same point and nothing is lost.
module turn_countdown #(
  parameter int CLK_FREQ     = 50000000,
  parameter int SEC_W        = 6,
  parameter int DEFAULT_SECS = 15
) (
  input  logic clock,
  input  logic reset,
  turn_countdown_if.slave bus
);

  localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_PAUSED  = 2'd2,
    S_EXPIRED = 2'd3
  } state_t;

  state_t           r_state;
  logic [SEC_W-1:0] r_remaining;
  logic [PW-1:0]    r_presc;
  logic             r_running;
  logic             r_tick;
  logic             r_expired;

  state_t           w_state_nxt;
  logic [SEC_W-1:0] w_rem_nxt;
  logic [PW-1:0]    w_presc_nxt;
  logic             w_tick_nxt;
  logic             w_exp_nxt;
  logic             w_terminal;
  logic [SEC_W-1:0] w_budget;

  assign w_terminal = (r_presc == PW'(CLK_FREQ - 1));
  assign w_budget   = (bus.load_secs == '0) ? SEC_W'(DEFAULT_SECS) : bus.load_secs;

  // Next-state and next-output decode, in event priority order.
  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_remaining;
    w_presc_nxt = r_presc;
    w_tick_nxt  = 1'b0;
    w_exp_nxt   = 1'b0;
    if (bus.start) begin
      w_rem_nxt   = w_budget;
      w_presc_nxt = '0;
      w_state_nxt = S_RUN;
    end else if (r_state == S_RUN || r_state == S_PAUSED) begin
      if (bus.move_done) begin
        // Cancel: remaining stays frozen for the display.
        w_state_nxt = S_IDLE;
      end else if (bus.pause) begin
        // Hold the prescaler; a pending terminal count waits for resume.
        w_state_nxt = S_PAUSED;
      end else begin
        w_state_nxt = S_RUN;
        if (w_terminal) begin
          w_presc_nxt = '0;
          if (r_remaining != '0) begin
            w_tick_nxt = 1'b1;
            w_rem_nxt  = r_remaining - SEC_W'(1);
            if (r_remaining == SEC_W'(1)) begin
              w_exp_nxt   = 1'b1;
              w_state_nxt = S_EXPIRED;
            end
          end
        end else begin
          w_presc_nxt = r_presc + PW'(1);
        end
      end
    end
  end

  // State and registered outputs; reset clears everything at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_presc     <= '0;
      r_running   <= 1'b0;
      r_tick      <= 1'b0;
      r_expired   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_rem_nxt;
      r_presc     <= w_presc_nxt;
      r_running   <= (w_state_nxt == S_RUN);
      r_tick      <= w_tick_nxt;
      r_expired   <= w_exp_nxt;
    end
  end

  assign bus.remaining = r_remaining;
  assign bus.running   = r_running;
  assign bus.sec_tick  = r_tick;
  assign bus.expired   = r_expired;
  assign bus.dbg_state = r_state;

endmodule
